// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch sequencer.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] pc1;
    logic [INST_W-1:0] pc2;
    logic [INST_W-1:0] inst1;
    logic [INST_W-1:0] inst2;
    logic              v2;
    logic              br1;
    logic              br2;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_npc.sv
// Next-PC priority mux: flush > branch unit > predictor > sequential.
module fetch_npc
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_r,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            bru,
  input  logic [PC_W-1:0] bru_target,
  input  logic            bp_taken,
  input  logic            bp_slot,
  input  logic [PC_W-1:0] bp_target,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] npc,
  output logic            v2,
  output logic            br1,
  output logic            br2
);

  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

  logic            slot1_taken;
  logic [PC_W-1:0] seq_pc;

  always_comb begin
    slot1_taken = bp_taken && !bp_slot;
    v2          = !pc_r[2] && !slot1_taken;
    br1         = slot1_taken;
    br2         = bp_taken && bp_slot && v2;
    // Blocks stop at the 8-byte boundary, so odd-word PCs step by 4.
    seq_pc      = pc_r + (pc_r[2] ? PC_W'(4) : PC_W'(8));
    redirect    = flush || bru;
    if (flush) begin
      redirect_pc = flush_pc & ALIGN;
    end else if (bru) begin
      redirect_pc = bru_target & ALIGN;
    end else begin
      redirect_pc = '0;
    end
    if (redirect) begin
      npc = redirect_pc;
    end else if (bp_taken) begin
      npc = bp_target & ALIGN;
    end else begin
      npc = seq_pc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the I-cache handshake
// and delivers instruction pairs, dropping responses made stale.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            icache_req_o,
  output logic [PC_W-1:0] icache_pc_1_o,
  output logic [PC_W-1:0] icache_pc_2_o,
  input  logic            icache_addr_ok_i,
  input  logic            icache_data_ok_i,
  input  logic [PC_W-1:0] icache_inst_1_i,
  input  logic [PC_W-1:0] icache_inst_2_i,
  input  logic            bp_taken_i,
  input  logic            bp_slot_i,
  input  logic [PC_W-1:0] bp_target_i,
  input  logic            bru_redirect_i,
  input  logic [PC_W-1:0] bru_target_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] flush_pc_i,
  input  logic            ib_full_i,
  output logic            fetch_valid_o,
  output logic            fetch_valid_2_o,
  output logic [PC_W-1:0] fetch_pc_1_o,
  output logic [PC_W-1:0] fetch_pc_2_o,
  output logic [PC_W-1:0] fetch_inst_1_o,
  output logic [PC_W-1:0] fetch_inst_2_o,
  output logic            fetch_br_1_o,
  output logic            fetch_br_2_o,
  output logic            if_flush_o
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc_r, pc_n;
  logic            discard, discard_n;
  logic            accept, deliver;

  logic [PC_W-1:0] req_pc;
  logic            v2_q, br1_q, br2_q;
  fetch_pair_t     pair_q;
  logic            valid_q;

  logic            redirect;
  logic [PC_W-1:0] redirect_pc, npc;
  logic            v2, br1, br2;

  fetch_npc #(.PC_W(PC_W)) u_npc (
    .pc_r        (pc_r),
    .flush       (flush_i),
    .flush_pc    (flush_pc_i),
    .bru         (bru_redirect_i),
    .bru_target  (bru_target_i),
    .bp_taken    (bp_taken_i),
    .bp_slot     (bp_slot_i),
    .bp_target   (bp_target_i),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .npc         (npc),
    .v2          (v2),
    .br1         (br1),
    .br2         (br2)
  );

  always_comb begin
    state_n      = state;
    pc_n         = pc_r;
    discard_n    = discard;
    accept       = 1'b0;
    deliver      = 1'b0;
    icache_req_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) pc_n = redirect_pc;
        if (!ib_full_i) state_n = REQ;
      end
      REQ: begin
        icache_req_o = 1'b1;
        if (icache_addr_ok_i) begin
          accept    = 1'b1;
          pc_n      = npc;
          discard_n = redirect;
          state_n   = WAIT;
        end else if (redirect) begin
          pc_n = redirect_pc;
        end
      end
      WAIT: begin
        if (redirect) pc_n = redirect_pc;
        if (icache_data_ok_i) begin
          // A redirect on the return cycle drops the data directly.
          deliver   = !discard && !redirect;
          discard_n = 1'b0;
          state_n   = ib_full_i ? IDLE : REQ;
        end else if (redirect) begin
          discard_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pc_r    <= RESET_PC;
      discard <= 1'b0;
      req_pc  <= '0;
      v2_q    <= 1'b0;
      br1_q   <= 1'b0;
      br2_q   <= 1'b0;
      pair_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc_r    <= pc_n;
      discard <= discard_n;
      valid_q <= deliver;
      if (accept) begin
        req_pc <= pc_r;
        v2_q   <= v2;
        br1_q  <= br1;
        br2_q  <= br2;
      end
      if (deliver) begin
        pair_q <= '{
          pc1:   req_pc,
          pc2:   req_pc + PC_W'(4),
          inst1: icache_inst_1_i,
          inst2: icache_inst_2_i,
          v2:    v2_q,
          br1:   br1_q,
          br2:   br2_q
        };
      end else begin
        pair_q.v2  <= 1'b0;
        pair_q.br1 <= 1'b0;
        pair_q.br2 <= 1'b0;
      end
    end
  end

  assign icache_pc_1_o   = pc_r;
  assign icache_pc_2_o   = pc_r + PC_W'(4);
  assign fetch_valid_o   = valid_q;
  assign fetch_valid_2_o = pair_q.v2;
  assign fetch_pc_1_o    = pair_q.pc1;
  assign fetch_pc_2_o    = pair_q.pc2;
  assign fetch_inst_1_o  = pair_q.inst1;
  assign fetch_inst_2_o  = pair_q.inst2;
  assign fetch_br_1_o    = pair_q.br1;
  assign fetch_br_2_o    = pair_q.br2;
  assign if_flush_o      = flush_i || bru_redirect_i;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req_o;
  logic [31:0] icache_pc_1_o, icache_pc_2_o;
  logic        icache_addr_ok_i, icache_data_ok_i;
  logic [31:0] icache_inst_1_i, icache_inst_2_i;
  logic        bp_taken_i, bp_slot_i;
  logic [31:0] bp_target_i;
  logic        bru_redirect_i;
  logic [31:0] bru_target_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        ib_full_i;
  logic        fetch_valid_o, fetch_valid_2_o;
  logic [31:0] fetch_pc_1_o, fetch_pc_2_o;
  logic [31:0] fetch_inst_1_o, fetch_inst_2_o;
  logic        fetch_br_1_o, fetch_br_2_o;
  logic        if_flush_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .icache_req_o     (icache_req_o),
    .icache_pc_1_o    (icache_pc_1_o),
    .icache_pc_2_o    (icache_pc_2_o),
    .icache_addr_ok_i (icache_addr_ok_i),
    .icache_data_ok_i (icache_data_ok_i),
    .icache_inst_1_i  (icache_inst_1_i),
    .icache_inst_2_i  (icache_inst_2_i),
    .bp_taken_i       (bp_taken_i),
    .bp_slot_i        (bp_slot_i),
    .bp_target_i      (bp_target_i),
    .bru_redirect_i   (bru_redirect_i),
    .bru_target_i     (bru_target_i),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .ib_full_i        (ib_full_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_valid_2_o  (fetch_valid_2_o),
    .fetch_pc_1_o     (fetch_pc_1_o),
    .fetch_pc_2_o     (fetch_pc_2_o),
    .fetch_inst_1_o   (fetch_inst_1_o),
    .fetch_inst_2_o   (fetch_inst_2_o),
    .fetch_br_1_o     (fetch_br_1_o),
    .fetch_br_2_o     (fetch_br_2_o),
    .if_flush_o       (if_flush_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    icache_addr_ok_i = 1'b0;
    icache_data_ok_i = 1'b0;
    icache_inst_1_i  = '0;
    icache_inst_2_i  = '0;
    bp_taken_i       = 1'b0;
    bp_slot_i        = 1'b0;
    bp_target_i      = '0;
    bru_redirect_i   = 1'b0;
    bru_target_i     = '0;
    flush_i          = 1'b0;
    flush_pc_i       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ib_full_i = 1'b0;
    quiet();
    cyc();
    cyc();
    n_tests++;
    if ({icache_req_o, fetch_valid_o, fetch_valid_2_o,
         fetch_br_1_o, fetch_br_2_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
        {icache_req_o, fetch_valid_o, fetch_valid_2_o,
         fetch_br_1_o, fetch_br_2_o});
    end
    n_tests++;
    if ({fetch_pc_1_o, fetch_pc_2_o, fetch_inst_1_o,
         fetch_inst_2_o} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
        {fetch_pc_1_o, fetch_pc_2_o, fetch_inst_1_o, fetch_inst_2_o});
    end
    n_tests++;
    if (icache_pc_1_o !== 32'h1c00_0000) begin
      n_fail++;
      $display("FAIL reset_pc: got %h want 1c000000", icache_pc_1_o);
    end
    rst = 1'b1;
    ib_full_i = 1'b1;
    cyc();
    cyc();
    n_tests++;
    if (icache_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_full: got req %b want 0", icache_req_o);
    end
  endtask

  task automatic test_sequential();
    ib_full_i = 1'b0;
    cyc();
    n_tests++;
    if ({icache_req_o, icache_pc_1_o, icache_pc_2_o} !==
        {1'b1, 32'h1c00_0000, 32'h1c00_0004}) begin
      n_fail++;
      $display("FAIL seq_req0: got %b %h %h want 1 1c000000 1c000004",
        icache_req_o, icache_pc_1_o, icache_pc_2_o);
    end
    icache_addr_ok_i = 1'b1;
    cyc();
    icache_addr_ok_i = 1'b0;
    n_tests++;
    if (icache_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_wait_noreq: got %b want 0", icache_req_o);
    end
    icache_data_ok_i = 1'b1;
    icache_inst_1_i  = 32'h1111_1111;
    icache_inst_2_i  = 32'h2222_2222;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o,
         fetch_pc_1_o, fetch_pc_2_o, fetch_inst_1_o, fetch_inst_2_o} !==
        {4'b1100, 32'h1c00_0000, 32'h1c00_0004,
         32'h1111_1111, 32'h2222_2222}) begin
      n_fail++;
      $display("FAIL seq_pair0: got %b%b%b%b %h %h %h %h",
        fetch_valid_o, fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o,
        fetch_pc_1_o, fetch_pc_2_o, fetch_inst_1_o, fetch_inst_2_o);
    end
    n_tests++;
    if ({icache_req_o, icache_pc_1_o} !== {1'b1, 32'h1c00_0008}) begin
      n_fail++;
      $display("FAIL seq_req1: got %b %h want 1 1c000008",
        icache_req_o, icache_pc_1_o);
    end
    bru_redirect_i = 1'b1;
    bru_target_i   = 32'h1c00_000c;
    #1;
    n_tests++;
    if (if_flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_if_flush: got %b want 1", if_flush_o);
    end
    cyc();
    bru_redirect_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, icache_pc_1_o, icache_pc_2_o} !==
        {1'b0, 32'h1c00_000c, 32'h1c00_0010}) begin
      n_fail++;
      $display("FAIL seq_odd_req: got %b %h %h want 0 1c00000c 1c000010",
        fetch_valid_o, icache_pc_1_o, icache_pc_2_o);
    end
    icache_addr_ok_i = 1'b1;
    cyc();
    icache_addr_ok_i = 1'b0;
    icache_data_ok_i = 1'b1;
    icache_inst_1_i  = 32'h3333_3333;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, fetch_valid_2_o, fetch_pc_1_o, fetch_inst_1_o,
         icache_pc_1_o} !==
        {2'b10, 32'h1c00_000c, 32'h3333_3333, 32'h1c00_0010}) begin
      n_fail++;
      $display("FAIL seq_odd_pair: got %b%b %h %h next %h",
        fetch_valid_o, fetch_valid_2_o, fetch_pc_1_o, fetch_inst_1_o,
        icache_pc_1_o);
    end
  endtask

  task automatic test_bp();
    bru_redirect_i = 1'b1;
    bru_target_i   = 32'h1c00_0000;
    cyc();
    bru_redirect_i = 1'b0;
    icache_addr_ok_i = 1'b1;
    bp_taken_i  = 1'b1;
    bp_slot_i   = 1'b0;
    bp_target_i = 32'h1c00_0100;
    cyc();
    quiet();
    icache_data_ok_i = 1'b1;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o,
         fetch_pc_1_o, icache_pc_1_o} !==
        {4'b1010, 32'h1c00_0000, 32'h1c00_0100}) begin
      n_fail++;
      $display("FAIL bp_slot1: got %b%b%b%b %h next %h want 1010 1c000000 1c000100",
        fetch_valid_o, fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o,
        fetch_pc_1_o, icache_pc_1_o);
    end
    icache_addr_ok_i = 1'b1;
    bp_taken_i  = 1'b1;
    bp_slot_i   = 1'b1;
    bp_target_i = 32'h1c00_0400;
    cyc();
    quiet();
    icache_data_ok_i = 1'b1;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o,
         fetch_pc_1_o, icache_pc_1_o} !==
        {4'b1101, 32'h1c00_0100, 32'h1c00_0400}) begin
      n_fail++;
      $display("FAIL bp_slot2: got %b%b%b%b %h next %h want 1101 1c000100 1c000400",
        fetch_valid_o, fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o,
        fetch_pc_1_o, icache_pc_1_o);
    end
  endtask

  task automatic test_redirect_wait();
    icache_addr_ok_i = 1'b1;
    cyc();
    icache_addr_ok_i = 1'b0;
    bru_redirect_i = 1'b1;
    bru_target_i   = 32'h1c00_0200;
    cyc();
    bru_redirect_i = 1'b0;
    icache_data_ok_i = 1'b1;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, icache_req_o, icache_pc_1_o} !==
        {2'b01, 32'h1c00_0200}) begin
      n_fail++;
      $display("FAIL redir_wait: got v%b r%b %h want v0 r1 1c000200",
        fetch_valid_o, icache_req_o, icache_pc_1_o);
    end
    icache_addr_ok_i = 1'b1;
    cyc();
    icache_addr_ok_i = 1'b0;
    icache_data_ok_i = 1'b1;
    bru_redirect_i   = 1'b1;
    bru_target_i     = 32'h1c00_0500;
    cyc();
    quiet();
    n_tests++;
    if ({fetch_valid_o, icache_pc_1_o} !== {1'b0, 32'h1c00_0500}) begin
      n_fail++;
      $display("FAIL redir_dataok: got v%b %h want v0 1c000500",
        fetch_valid_o, icache_pc_1_o);
    end
    icache_addr_ok_i = 1'b1;
    cyc();
    icache_addr_ok_i = 1'b0;
    icache_data_ok_i = 1'b1;
    icache_inst_1_i  = 32'h5555_5555;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, fetch_pc_1_o, fetch_inst_1_o} !==
        {1'b1, 32'h1c00_0500, 32'h5555_5555}) begin
      n_fail++;
      $display("FAIL redir_after_dataok: got v%b %h %h want v1 1c000500 55555555",
        fetch_valid_o, fetch_pc_1_o, fetch_inst_1_o);
    end
  endtask

  task automatic test_flush_priority();
    flush_i        = 1'b1;
    flush_pc_i     = 32'h1c00_8000;
    bru_redirect_i = 1'b1;
    bru_target_i   = 32'h1c00_0300;
    #1;
    n_tests++;
    if (if_flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_if_flush: got %b want 1", if_flush_o);
    end
    cyc();
    quiet();
    n_tests++;
    if (icache_pc_1_o !== 32'h1c00_8000) begin
      n_fail++;
      $display("FAIL flush_prio: got %h want 1c008000", icache_pc_1_o);
    end
  endtask

  task automatic test_ib_full();
    icache_addr_ok_i = 1'b1;
    cyc();
    icache_addr_ok_i = 1'b0;
    icache_data_ok_i = 1'b1;
    ib_full_i        = 1'b1;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, icache_req_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL ibfull_deliver: got v%b r%b want v1 r0",
        fetch_valid_o, icache_req_o);
    end
    cyc();
    n_tests++;
    if (icache_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ibfull_idle: got r%b want r0", icache_req_o);
    end
    ib_full_i = 1'b0;
    cyc();
    n_tests++;
    if ({icache_req_o, icache_pc_1_o} !== {1'b1, 32'h1c00_8008}) begin
      n_fail++;
      $display("FAIL ibfull_release: got r%b %h want r1 1c008008",
        icache_req_o, icache_pc_1_o);
    end
  endtask

  task automatic test_wrap();
    bru_redirect_i = 1'b1;
    bru_target_i   = 32'hffff_fffb;
    cyc();
    bru_redirect_i = 1'b0;
    n_tests++;
    if (icache_pc_1_o !== 32'hffff_fff8) begin
      n_fail++;
      $display("FAIL wrap_align: got %h want fffffff8", icache_pc_1_o);
    end
    icache_addr_ok_i = 1'b1;
    cyc();
    icache_addr_ok_i = 1'b0;
    icache_data_ok_i = 1'b1;
    cyc();
    icache_data_ok_i = 1'b0;
    n_tests++;
    if ({fetch_valid_o, fetch_valid_2_o, fetch_pc_1_o, fetch_pc_2_o,
         icache_pc_1_o} !==
        {2'b11, 32'hffff_fff8, 32'hffff_fffc, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_pc: got %b%b %h %h next %h",
        fetch_valid_o, fetch_valid_2_o, fetch_pc_1_o, fetch_pc_2_o,
        icache_pc_1_o);
    end
  endtask

  // Transaction-level reference: one outstanding block, a stale flag
  // for redirected blocks, and the PC the front end should ask for.
  task automatic test_random();
    logic [31:0] m_pc;
    bit          m_want, m_out, m_stale, m_valid;
    logic [31:0] b_pc;
    bit          b_v2, b_br1, b_br2;
    logic [31:0] e_pc, e_i1, e_i2;
    bit          e_v2, e_br1, e_br2;
    bit          redir, s1;
    logic [31:0] tgt;
    rst = 1'b0;
    quiet();
    cyc();
    m_pc = 32'h1c00_0000;
    m_want = 0; m_out = 0; m_stale = 0; m_valid = 0;
    b_pc = '0; b_v2 = 0; b_br1 = 0; b_br2 = 0;
    e_pc = '0; e_i1 = '0; e_i2 = '0; e_v2 = 0; e_br1 = 0; e_br2 = 0;
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(199) != 0);
      ib_full_i        = ($urandom_range(4) == 0);
      icache_addr_ok_i = $urandom_range(1);
      icache_data_ok_i = m_out && rst && ($urandom_range(2) == 0);
      icache_inst_1_i  = $urandom;
      icache_inst_2_i  = $urandom;
      bp_taken_i       = ($urandom_range(3) == 0);
      bp_slot_i        = $urandom_range(1);
      bp_target_i      = $urandom;
      bru_redirect_i   = ($urandom_range(19) == 0);
      bru_target_i     = $urandom;
      flush_i          = ($urandom_range(29) == 0);
      flush_pc_i       = $urandom;
      #1;
      redir = flush_i || bru_redirect_i;
      tgt   = (flush_i ? flush_pc_i : bru_target_i) & ~32'd3;
      n_tests++;
      if (icache_req_o !== m_want) begin
        n_fail++;
        $display("FAIL rand_req @%0d: got %b want %b", i, icache_req_o, m_want);
      end
      if (m_want) begin
        n_tests++;
        if ({icache_pc_1_o, icache_pc_2_o} !== {m_pc, m_pc + 32'd4}) begin
          n_fail++;
          $display("FAIL rand_req_pc @%0d: got %h %h want %h", i,
            icache_pc_1_o, icache_pc_2_o, m_pc);
        end
      end
      n_tests++;
      if (if_flush_o !== redir) begin
        n_fail++;
        $display("FAIL rand_if_flush @%0d: got %b want %b", i, if_flush_o, redir);
      end
      m_valid = 0;
      if (!rst) begin
        m_pc = 32'h1c00_0000;
        m_want = 0; m_out = 0; m_stale = 0;
      end else if (m_want) begin
        if (icache_addr_ok_i) begin
          s1    = bp_taken_i && !bp_slot_i;
          b_pc  = m_pc;
          b_v2  = !m_pc[2] && !s1;
          b_br1 = s1;
          b_br2 = bp_taken_i && bp_slot_i && b_v2;
          if (redir) m_pc = tgt;
          else if (bp_taken_i) m_pc = bp_target_i & ~32'd3;
          else m_pc = m_pc + (m_pc[2] ? 32'd4 : 32'd8);
          m_stale = redir;
          m_out = 1; m_want = 0;
        end else if (redir) begin
          m_pc = tgt;
        end
      end else if (m_out) begin
        if (icache_data_ok_i) begin
          if (!m_stale && !redir) begin
            m_valid = 1;
            e_pc = b_pc; e_v2 = b_v2; e_br1 = b_br1; e_br2 = b_br2;
            e_i1 = icache_inst_1_i; e_i2 = icache_inst_2_i;
          end
          m_stale = 0; m_out = 0;
          m_want = !ib_full_i;
        end else if (redir) begin
          m_stale = 1;
        end
        if (redir) m_pc = tgt;
      end else begin
        if (redir) m_pc = tgt;
        if (!ib_full_i) m_want = 1;
      end
      cyc();
      n_tests++;
      if (fetch_valid_o !== m_valid) begin
        n_fail++;
        $display("FAIL rand_valid @%0d: got %b want %b", i, fetch_valid_o, m_valid);
      end
      if (m_valid) begin
        n_tests++;
        if ({fetch_pc_1_o, fetch_pc_2_o, fetch_inst_1_o, fetch_inst_2_o,
             fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o} !==
            {e_pc, e_pc + 32'd4, e_i1, e_i2, e_v2, e_br1, e_br2}) begin
          n_fail++;
          $display("FAIL rand_pair @%0d: got %h %h %h %h %b%b%b want %h %h %h %b%b%b",
            i, fetch_pc_1_o, fetch_pc_2_o, fetch_inst_1_o, fetch_inst_2_o,
            fetch_valid_2_o, fetch_br_1_o, fetch_br_2_o,
            e_pc, e_i1, e_i2, e_v2, e_br1, e_br2);
        end
      end
    end
    quiet();
  endtask

  initial begin
    rst = 1'b0;
    ib_full_i = 1'b0;
    quiet();
    test_reset();
    test_sequential();
    test_bp();
    test_redirect_wait();
    test_flush_priority();
    test_ib_full();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
